// File: rtl/lbp_engine.sv
// Local Binary Pattern engine: streams an IMG_W x IMG_H gray image and writes one 8-bit code per pixel.
// Optional build macro LBP_WINDOW_REUSE_EN enables sliding-window column reuse (3 reads instead of 9).
module lbp_engine #(
  parameter int IMG_W        = 128,
  parameter int IMG_H        = 128,
  parameter int PIX_W        = 8,
  parameter int ADDR_W       = 14,
  parameter int BORDER_WRITE = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic              gray_ready,
  input  logic [PIX_W-1:0]  gray_data,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              lbp_valid,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {IDLE, SCAN, FETCH, EMIT, DONE} state_t;

  state_t state_reg, state_next;

  logic [XW-1:0]     x_reg;
  logic [YW-1:0]     y_reg;
  logic [ADDR_W-1:0] lin_reg;
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [PIX_W-1:0]  win_reg [0:2][0:2];
  logic [7:0]        code;
  logic              is_border;
  logic              is_last;
  logic              reuse_reg;
  logic              reuse_now;
  logic [3:0]        n_reads;
  logic [ADDR_W-1:0] nw_addr;

  // Window slot of read index k in the full fetch: centre first, then neighbours bit0..bit7.
  function automatic logic [1:0] nb_row(input logic [3:0] k);
    case (k)
      4'd1, 4'd2, 4'd3: nb_row = 2'd0;
      4'd0, 4'd4, 4'd5: nb_row = 2'd1;
      default:          nb_row = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] nb_col(input logic [3:0] k);
    case (k)
      4'd1, 4'd4, 4'd6: nb_col = 2'd0;
      4'd0, 4'd2, 4'd7: nb_col = 2'd1;
      default:          nb_col = 2'd2;
    endcase
  endfunction

  // A reuse fetch only reads the new right column, rows top to bottom.
  function automatic logic [1:0] rd_row(input logic [3:0] k, input logic reuse);
    rd_row = reuse ? k[1:0] : nb_row(k);
  endfunction

  function automatic logic [1:0] rd_col(input logic [3:0] k, input logic reuse);
    rd_col = reuse ? 2'd2 : nb_col(k);
  endfunction

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] nw,
                                                input logic [3:0] k, input logic reuse);
    logic [1:0]        r;
    logic [ADDR_W-1:0] roff;
    r = rd_row(k, reuse);
    case (r)
      2'd0:    roff = '0;
      2'd1:    roff = W_A;
      default: roff = W_A << 1;
    endcase
    rd_addr = nw + roff + ADDR_W'(rd_col(k, reuse));
  endfunction

  assign is_border = (x_reg == '0) || (y_reg == '0) || (x_reg == X_LAST) || (y_reg == Y_LAST);
  assign is_last   = (x_reg == X_LAST) && (y_reg == Y_LAST);
  assign n_reads   = reuse_reg ? 4'd3 : 4'd9;
  assign nw_addr   = lin_reg - W_A - ADDR_W'(1);

`ifdef LBP_WINDOW_REUSE_EN
  logic prev_int_reg;
  // Raster order guarantees that an interior predecessor sits at (x-1,y).
  assign reuse_now = prev_int_reg;
`else
  assign reuse_now = 1'b0;
  assign reuse_reg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (gray_ready) state_next = SCAN;
      SCAN: begin
        if (!is_border)   state_next = FETCH;
        else if (is_last) state_next = DONE;
      end
      FETCH: if (cnt_reg == n_reads) state_next = EMIT;
      EMIT:  state_next = SCAN;
      DONE:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gray_addr = addr_reg;
    gray_req  = (state_reg == FETCH) && (cnt_reg < n_reads);
    lbp_addr  = lin_reg;
    lbp_valid = (state_reg == EMIT) ||
                ((state_reg == SCAN) && is_border && (BORDER_WRITE != 0));
    lbp_data  = (state_reg == EMIT) ? code : 8'h00;
    finish    = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_reg    <= '0;
      y_reg    <= '0;
      lin_reg  <= '0;
      cnt_reg  <= '0;
      addr_reg <= '0;
`ifdef LBP_WINDOW_REUSE_EN
      prev_int_reg <= 1'b0;
      reuse_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          x_reg   <= '0;
          y_reg   <= '0;
          lin_reg <= '0;
        end
        SCAN: begin
          if (is_border) begin
`ifdef LBP_WINDOW_REUSE_EN
            prev_int_reg <= 1'b0;
`endif
            if (!is_last) begin
              lin_reg <= lin_reg + ADDR_W'(1);
              if (x_reg == X_LAST) begin
                x_reg <= '0;
                y_reg <= y_reg + YW'(1);
              end else begin
                x_reg <= x_reg + XW'(1);
              end
            end
          end else begin
            cnt_reg  <= '0;
            addr_reg <= rd_addr(nw_addr, 4'd0, reuse_now);
`ifdef LBP_WINDOW_REUSE_EN
            reuse_reg <= reuse_now;
`endif
          end
        end
        FETCH: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg + 4'd1 < n_reads)
            addr_reg <= rd_addr(nw_addr, cnt_reg + 4'd1, reuse_reg);
        end
        EMIT: begin
          // Interior pixels are never at the row end, so only x advances here.
          x_reg   <= x_reg + XW'(1);
          lin_reg <= lin_reg + ADDR_W'(1);
`ifdef LBP_WINDOW_REUSE_EN
          prev_int_reg <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Read data for index k returns while cnt_reg == k+1.
  always_ff @(posedge clk) begin
`ifdef LBP_WINDOW_REUSE_EN
    if ((state_reg == SCAN) && !is_border && reuse_now) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= win_reg[r][1];
        win_reg[r][1] <= win_reg[r][2];
      end
    end
`endif
    if ((state_reg == FETCH) && (cnt_reg != 4'd0))
      win_reg[rd_row(cnt_reg - 4'd1, reuse_reg)][rd_col(cnt_reg - 4'd1, reuse_reg)] <= gray_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_code
      assign code[gi] = (win_reg[nb_row(4'(gi + 1))][nb_col(4'(gi + 1))] >= win_reg[1][1]);
    end
  endgenerate

endmodule

// File: doc/lbp_engine.md
# lbp_engine

Parametrised Local Binary Pattern engine that streams an IMG_W×IMG_H grayscale image from the gray memory and writes one 8-bit LBP code per pixel to the LBP memory. It generalises the fixed 128×128 LBP block to arbitrary image size and pixel width. It adds an optional zero-write of border pixels and a sliding-window read-reuse mode, and sits between the gray image RAM and the LBP result RAM in the image pipeline.

## Interface
- IMG_W, 128, image width in pixels (≥3)
- IMG_H, 128, image height in pixels (≥3)
- PIX_W, 8, gray pixel width in bits
- ADDR_W, 14, address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- BORDER_WRITE, 1, 1 = write 0x00 to every border pixel; 0 = border pixels not written
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- gray_addr  output  ADDR_W  gray RAM read address, raster order (y*IMG_W+x)
- gray_req  output  1  read strobe; one read per cycle when high
- gray_ready  input  1  gray RAM loaded and ready; sampled in IDLE only
- gray_data  input  PIX_W  read data, valid the cycle after gray_req/gray_addr
- lbp_addr  output  ADDR_W  LBP RAM write address
- lbp_valid  output  1  one-cycle write strobe for lbp_addr/lbp_data
- lbp_data  output  8  LBP code
- finish  output  1  whole image written; sticky until reset

## Operation
- Reset (reset==0 at a rising edge): gray_addr=0, gray_req=0, lbp_addr=0, lbp_valid=0, lbp_data=0, finish=0, state=IDLE. Reset mid-frame aborts the frame; there is no resume.
- States: IDLE → SCAN → FETCH → EMIT → SCAN … → DONE.
- IDLE: wait for gray_ready==1, then go to SCAN with x=0, y=0.
- SCAN: classify pixel (x,y). A border pixel (x==0, y==0, x==IMG_W-1 or y==IMG_H-1) with BORDER_WRITE=1 emits lbp_data=0x00 at y*IMG_W+x this cycle. With BORDER_WRITE=0 it is skipped with no write. Both cases advance in one cycle. An interior pixel goes to FETCH.
- FETCH: issues reads back-to-back, one per cycle, gray_req=1; comparisons are taken on the returning data.
- Neighbour bit order: bit0 (x-1,y-1), bit1 (x,y-1), bit2 (x+1,y-1), bit3 (x-1,y), bit4 (x+1,y), bit5 (x-1,y+1), bit6 (x,y+1), bit7 (x+1,y+1).
- Bit = 1 iff neighbour ≥ centre, unsigned PIX_W compare.
- Full fetch order: centre first, then neighbours bit0..bit7 (9 reads).
- EMIT: lbp_valid=1 for exactly one cycle with lbp_addr=y*IMG_W+x and lbp_data=code, then return to SCAN at the next raster pixel.
- After pixel (IMG_W-1, IMG_H-1) is handled, enter DONE. DONE: finish=1 and gray_req=0, lbp_valid=0, held until reset.
- gray_req is 0 outside FETCH. gray_addr holds its last value when gray_req=0.
- Address arithmetic is ADDR_W bits; addresses of interior neighbours never wrap.

## Timing
- Read latency 1: address issued at cycle t, data sampled at t+1.
- Full fetch: addresses at cycles 0..8, last data at cycle 9, lbp_valid at cycle 10.
- Reuse fetch (macro on): 3 addresses at cycles 0..2 (column x+1: rows y-1, y, y+1), lbp_valid at cycle 4.
- Border pixel: 1 cycle each, whether written or skipped.
- lbp_valid never asserts in consecutive cycles for interior pixels. Border zero-writes may be consecutive.
- finish rises the cycle after the last write/skip and is never asserted together with lbp_valid.

## Configuration
- LBP_WINDOW_REUSE_EN defined: a 3×3 window register holds pixels. When the previous handled pixel was interior at (x-1,y), columns shift left and only the new right column is read (3 reads). The first interior pixel of each row (x=1) always does a full 9-read fetch.
- Not defined: every interior pixel does a full 9-read fetch; no window shift logic.
- LBP codes and write order are identical in both builds; only read count and cycle timing differ.

## Test plan
- 3×3 image, centre 100, neighbours bit0..7 = 90,100,110,120,80,100,130,99 → single write lbp_addr=4, lbp_data=0x6E. With BORDER_WRITE=1, eight 0x00 writes go to addresses 0,1,2,3,5,6,7,8. finish=1.
- 128×128 flat image (all 50), BORDER_WRITE=0 → 126*126 writes, all lbp_data=0xFF, no write to any border address, finish sticky.
- 8×4 random image → read count is 48 gray_req cycles with LBP_WINDOW_REUSE_EN, 108 without. All 12 interior codes match a golden model in both builds.
- Full fetch timing: first gray_req at cycle 0 → lbp_valid exactly at cycle 10. Reuse fetch for the next pixel → lbp_valid 4 cycles after its first gray_req.
- gray_ready held 0 for 20 cycles after reset release → gray_req stays 0. Then gray_ready=1 → first read of gray_addr=IMG_W+1 after border handling.
- reset=0 pulsed mid-frame during FETCH → next cycle all outputs at reset values. The restarted frame produces the full, correct write sequence.
